// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and control-word type for the multicycle
// MIPS main controller.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] RST    = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] EXEC   = 4'd3;
    localparam logic [3:0] RWB    = 4'd4;
    localparam logic [3:0] MEMADR = 4'd5;
    localparam logic [3:0] MEMRD  = 4'd6;
    localparam logic [3:0] MEMWB  = 4'd7;
    localparam logic [3:0] MEMWR  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] ADDIEX = 4'd11;
    localparam logic [3:0] ADDIWB = 4'd12;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode from FSM state; IRWrite/PCWrite in FETCH
// additionally wait for mem_ready.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]  state,
    input  logic        mem_ready,
    output ctrl_word_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state sequencing,
// illegal-opcode pulse and retired-instruction counter.
//
// state  | meaning
// RST    | post-reset idle, all outputs low
// FETCH  | read instruction, PC+4 (waits on mem_ready)
// DECODE | register read, branch target into ALUOut
// EXEC   | R-type ALU operation
// RWB    | R-type register writeback
// MEMADR | lw/sw address compute
// MEMRD  | data read (waits on mem_ready)
// MEMWB  | lw register writeback
// MEMWR  | data write (waits on mem_ready)
// BRANCH | beq compare and conditional PC update
// JUMP   | jump target into PC
// ADDIEX | addi ALU operation
// ADDIWB | addi register writeback
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALU_Op,
    output logic [1:0]       PCSrc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       retire;
    ctrl_word_t ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RST:    state_next = FETCH;
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = EXEC;
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    OP_ADDI:      state_next = ADDIEX;
                    default:      state_next = FETCH;
                endcase
            end
            EXEC:   state_next = RWB;
            MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWR:  if (mem_ready) state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            RWB, MEMWB, BRANCH, JUMP, ADDIWB: state_next = FETCH;
            default: state_next = RST;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALU_Op      = ctrl.alu_op;
    assign PCSrc       = ctrl.pc_src;

    // A store retires only on the cycle its write is accepted.
    assign retire = (state == RWB) || (state == MEMWB) || (state == BRANCH) ||
                    (state == JUMP) || (state == ADDIWB) ||
                    ((state == MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            illegal_op <= (state == DECODE) && !is_legal_op(opcode);
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALU_Op, PCSrc;
    logic [31:0] instr_count;

    logic s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
    logic s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_illegal_op;
    logic [1:0] s_ALUSrcB, s_ALU_Op, s_PCSrc;
    logic [3:0] s_instr_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    mc_main_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .PCSrc(PCSrc),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    mc_main_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD),
        .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
        .MemtoReg(s_MemtoReg), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
        .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALU_Op(s_ALU_Op), .PCSrc(s_PCSrc),
        .illegal_op(s_illegal_op), .instr_count(s_instr_count)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALU_Op,PCSrc}
    logic [15:0] cw;
    assign cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_Op, PCSrc};

    localparam logic [15:0] C_ZERO    = 16'h0000;
    localparam logic [15:0] C_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] C_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] C_DECODE  = {10'b0000000000, 2'b11, 2'b00, 2'b00};
    localparam logic [15:0] C_EXEC    = {10'b0000000001, 2'b00, 2'b10, 2'b00};
    localparam logic [15:0] C_RWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] C_MEMADR  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] C_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] C_MEMWB   = {10'b0000001010, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] C_MEMWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] C_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 2'b01};
    localparam logic [15:0] C_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] C_ADDIEX  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] C_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
        #1;
        checks++;
        if (cw !== C_ZERO || illegal_op !== 1'b0 || instr_count !== 32'd0 || s_instr_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: cw=%b ill=%b cnt=%0d cnt4=%0d, want all 0", cw, illegal_op, instr_count, s_instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cw !== C_ZERO) begin
            errors++;
            $display("FAIL reset_rst_state: cw=%b want %b", cw, C_ZERO);
        end
        tick();
    endtask

    task automatic test_rtype();
        logic [15:0] exp_cw [4];
        logic        mr [4];
        exp_cw = '{C_FETCH_R, C_DECODE, C_EXEC, C_RWB};
        mr     = '{1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i]) begin
                errors++;
                $display("FAIL rtype cycle %0d: cw=%b want %b", i, cw, exp_cw[i]);
            end
            tick();
        end
        exp_count = 1;
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL rtype_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_lw_stall();
        logic [15:0] exp_cw [7];
        logic        mr [7];
        exp_cw = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
        mr     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: cw=%b want %b", i, cw, exp_cw[i]);
            end
            tick();
        end
        exp_count = 2;
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL lw_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_beq();
        logic [15:0] exp_cw [4];
        logic        mr [4];
        exp_cw = '{C_FETCH_R, C_DECODE, C_BRANCH, C_FETCH_W};
        mr     = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i]) begin
                errors++;
                $display("FAIL beq cycle %0d: cw=%b want %b", i, cw, exp_cw[i]);
            end
            tick();
        end
        exp_count = 3;
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL beq_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp_cw [4];
        logic        mr [4];
        logic        ill [4];
        exp_cw = '{C_FETCH_R, C_DECODE, C_FETCH_W, C_FETCH_W};
        mr     = '{1'b1, 1'b1, 1'b0, 1'b0};
        ill    = '{1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i] || illegal_op !== ill[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: cw=%b ill=%b want %b ill=%b", i, cw, illegal_op, exp_cw[i], ill[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL illegal_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_fetch_stall_addi();
        logic [15:0] exp_cw [7];
        logic        mr [7];
        exp_cw = '{C_FETCH_W, C_FETCH_W, C_FETCH_W, C_FETCH_R, C_DECODE, C_ADDIEX, C_ADDIWB};
        mr     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 6'b001000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i]) begin
                errors++;
                $display("FAIL addi cycle %0d: cw=%b want %b", i, cw, exp_cw[i]);
            end
            tick();
        end
        exp_count = 4;
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL addi_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_sw();
        logic [15:0] exp_cw [6];
        logic        mr [6];
        exp_cw = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_FETCH_W};
        mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (cw !== exp_cw[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: cw=%b want %b", i, cw, exp_cw[i]);
            end
            if (i == 4) begin
                checks++;
                if (instr_count !== 32'(exp_count)) begin
                    errors++;
                    $display("FAIL sw_count_early: got %0d want %0d", instr_count, exp_count);
                end
            end
            tick();
        end
        exp_count = 5;
        checks++;
        if (instr_count !== 32'(exp_count)) begin
            errors++;
            $display("FAIL sw_count: got %0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_memwr();
        opcode = 6'b101011;
        mem_ready = 1'b1; tick();
        mem_ready = 1'b1; tick();
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; #1;
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_memwr: MemWrite=%b want 1", MemWrite);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (cw !== C_ZERO || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_async: cw=%b cnt=%0d want %b cnt=0", cw, instr_count, C_ZERO);
        end
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (cw !== C_ZERO) begin
            errors++;
            $display("FAIL abort_rst_state: cw=%b want %b", cw, C_ZERO);
        end
        tick();
        mem_ready = 1'b0; #1;
        checks++;
        if (cw !== C_FETCH_W) begin
            errors++;
            $display("FAIL abort_refetch: cw=%b want %b", cw, C_FETCH_W);
        end
        tick();
    endtask

    task automatic test_jump_wrap();
        opcode = 6'b000010;
        for (int k = 1; k <= 17; k++) begin
            mem_ready = 1'b1; tick();
            tick();
            #1;
            checks++;
            if (cw !== C_JUMP) begin
                errors++;
                $display("FAIL jump %0d: cw=%b want %b", k, cw, C_JUMP);
            end
            tick();
            exp_count++;
            checks++;
            if (instr_count !== 32'(exp_count) || s_instr_count !== 4'(exp_count % 16)) begin
                errors++;
                $display("FAIL jump_count %0d: cnt=%0d cnt4=%0d want %0d %0d", k, instr_count, s_instr_count, exp_count, exp_count % 16);
            end
        end
        checks++;
        if (s_instr_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_final: cnt4=%0d want 1", s_instr_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'b000000;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_fetch_stall_addi();
        test_sw();
        test_reset_mid_memwr();
        test_jump_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
